// File: rtl/checker_pkg.sv
// checker_pkg: shared types and constants for the output_checker block.
// Rev 1.0
`default_nettype none

package checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH = 11;
  // Don't-care flag sits just above the expected value in each memory word
  localparam int DC_BIT = DEFAULT_WIDTH;

endpackage

`default_nettype wire

// File: rtl/output_checker_if.sv
// output_checker_if: stimulus, load and verdict signals of the output checker.
// Rev 1.0
`default_nettype none

interface output_checker_if #(
  parameter int WIDTH = checker_pkg::DEFAULT_WIDTH,
  parameter int DEPTH = 64
);
  localparam int AW = $clog2(DEPTH);

  logic             posedge_big_clk;
  logic [WIDTH-1:0] output_signal;
  logic             start;
  logic [AW:0]      seq_len;
  logic             load_en;
  logic [AW-1:0]    load_addr;
  logic [WIDTH:0]   load_data;

  logic             busy;
  logic             done;
  logic             pass;
  logic [AW:0]      mismatch_count;
  logic [AW-1:0]    first_fail_idx;
  logic             sample_valid;
  logic [WIDTH-1:0] sample_value;

  modport master (
    output posedge_big_clk, output_signal, start, seq_len,
           load_en, load_addr, load_data,
    input  busy, done, pass, mismatch_count, first_fail_idx,
           sample_valid, sample_value
  );

  modport slave (
    input  posedge_big_clk, output_signal, start, seq_len,
           load_en, load_addr, load_data,
    output busy, done, pass, mismatch_count, first_fail_idx,
           sample_valid, sample_value
  );

endinterface

`default_nettype wire

// File: rtl/big_tick_detect.sv
// big_tick_detect: one-cycle tick on each rising edge of the time-unit strobe.
// Rev 1.0
`default_nettype none

module big_tick_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic posedge_big_clk,
  output logic tick
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b0;
    end else begin
      prev <= posedge_big_clk;
    end
  end

  assign tick = posedge_big_clk & ~prev;

endmodule

`default_nettype wire

// File: rtl/output_checker.sv
// output_checker: compares one sample per time unit against a preloaded sequence.
// Rev 1.0
`default_nettype none

module output_checker
  import checker_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 64,
  parameter int SKIP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output_checker_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
  localparam logic [SW-1:0] SKIP_INIT = SW'(SKIP);
  localparam logic [AW:0]   ONE       = 1;
  localparam logic [AW:0]   CNT_MAX   = '1;

  state_t           state;
  state_t           state_next;
  logic             tick;
  logic [WIDTH:0]   expected_memory [DEPTH];

  logic [AW-1:0]    idx;
  logic [AW:0]      len;
  logic [SW-1:0]    skip_cnt;
  logic [AW:0]      mcount;
  logic [AW-1:0]    ffi;
  logic             svalid;
  logic [WIDTH-1:0] svalue;

  logic             busy_w;
  logic             start_ok;
  logic             check_tick;
  logic             is_last;
  logic             mismatch;
  logic [WIDTH:0]   exp_word;

  big_tick_detect u_tick (
    .clk             (clk),
    .rst_n           (rst_n),
    .posedge_big_clk (bus.posedge_big_clk),
    .tick            (tick)
  );

  assign busy_w     = (state == ARMED) || (state == CHECK);
  assign start_ok   = bus.start && !busy_w;
  assign check_tick = (state == CHECK) && tick;
  assign exp_word   = expected_memory[idx];
  assign is_last    = ({1'b0, idx} == (len - ONE));
  assign mismatch   = check_tick && !exp_word[WIDTH] &&
                      (exp_word[WIDTH-1:0] != bus.output_signal);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          if (bus.seq_len == '0) begin
            state_next = DONE;
          end else if (SKIP == 0) begin
            state_next = CHECK;
          end else begin
            state_next = ARMED;
          end
        end
      end
      ARMED: begin
        if (tick && (skip_cnt == SW'(1))) begin
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (tick && is_last) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      len      <= '0;
      skip_cnt <= '0;
      mcount   <= '0;
      ffi      <= '0;
      svalid   <= 1'b0;
      svalue   <= '0;
    end else if (start_ok) begin
      // A tick coinciding with start is dropped: nothing below runs this cycle
      idx      <= '0;
      len      <= bus.seq_len;
      skip_cnt <= SKIP_INIT;
      mcount   <= '0;
      ffi      <= '0;
      svalid   <= 1'b0;
    end else begin
      svalid <= check_tick;
      if ((state == ARMED) && tick) begin
        skip_cnt <= skip_cnt - SW'(1);
      end
      if (check_tick) begin
        svalue <= bus.output_signal;
        if (mismatch) begin
          if (mcount == '0) begin
            ffi <= idx;
          end
          if (mcount != CNT_MAX) begin
            mcount <= mcount + ONE;
          end
        end
        if (!is_last) begin
          idx <= idx + AW'(1);
        end
      end
    end
  end

  // Expected values survive reset; loads are refused while a run is active
  always_ff @(posedge clk) begin
    if (bus.load_en && !busy_w) begin
      expected_memory[bus.load_addr] <= bus.load_data;
    end
  end

  assign bus.busy           = busy_w;
  assign bus.done           = (state == DONE);
  assign bus.pass           = (state == DONE) && (mcount == '0);
  assign bus.mismatch_count = mcount;
  assign bus.first_fail_idx = ffi;
  assign bus.sample_valid   = svalid;
  assign bus.sample_value   = svalue;

endmodule

`default_nettype wire

// File: tb/tb_output_checker.sv
// tb_output_checker: scoreboard bench for output_checker with directed vectors.
// Rev 1.0
`default_nettype none

module tb_output_checker;
  import checker_pkg::*;

  localparam int WIDTH = 11;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  typedef struct {
    logic [WIDTH-1:0] value;
    logic [AW:0]      mcount;
    logic [AW-1:0]    ffi;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  output_checker_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  output_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SKIP(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int               checks   = 0;
  int               failures = 0;
  exp_t             sb[$];
  exp_t             sb_item;
  logic [WIDTH:0]   model_mem [DEPTH];
  logic [WIDTH-1:0] drv [4];
  logic [AW:0]      m_cnt;
  logic [AW-1:0]    m_ffi;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  // Monitor: every sample_valid pops one expected entry
  always @(negedge clk) begin
    if (rst_n && bus.sample_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_sample: got value %0d expected no sample", bus.sample_value);
      end else begin
        sb_item = sb.pop_front();
        check("sample_value", 32'(bus.sample_value), 32'(sb_item.value));
        check("sample_mcount", 32'(bus.mismatch_count), 32'(sb_item.mcount));
        check("sample_ffi", 32'(bus.first_fail_idx), 32'(sb_item.ffi));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int addr, input logic [WIDTH:0] data);
    bus.load_en   = 1'b1;
    bus.load_addr = AW'(addr);
    bus.load_data = data;
    cyc();
    bus.load_en   = 1'b0;
    model_mem[addr] = data;
  endtask

  task automatic load_table();
    load(0, 12'd5);
    load(1, 12'd100);
    load(2, 12'd0);
    load(3, 12'd2047);
  endtask

  task automatic big_tick(input logic [WIDTH-1:0] v, input int hold, input bit checked, input int i);
    exp_t e;
    if (checked) begin
      if (!model_mem[i][WIDTH] && (model_mem[i][WIDTH-1:0] != v)) begin
        if (m_cnt == 0) m_ffi = AW'(i);
        m_cnt = m_cnt + 1'b1;
      end
      e.value  = v;
      e.mcount = m_cnt;
      e.ffi    = m_ffi;
      sb.push_back(e);
    end
    bus.output_signal   = v;
    bus.posedge_big_clk = 1'b1;
    repeat (hold) cyc();
    bus.posedge_big_clk = 1'b0;
    repeat (2) cyc();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_pass"}, 32'(bus.pass), 0);
    check({tag, "_svalid"}, 32'(bus.sample_valid), 0);
    check({tag, "_svalue"}, 32'(bus.sample_value), 0);
    check({tag, "_mcount"}, 32'(bus.mismatch_count), 0);
    check({tag, "_ffi"}, 32'(bus.first_fail_idx), 0);
  endtask

  // One run of n checked ticks preceded by the skip tick (value 777, never checked)
  task automatic run(input int n, input int hold, input int rst_after,
                     input bit tick_start, input bit poke);
    m_cnt = '0;
    m_ffi = '0;
    if (tick_start) begin
      bus.posedge_big_clk = 1'b1;
      bus.output_signal   = 11'd0;
    end
    bus.start   = 1'b1;
    bus.seq_len = (AW+1)'(n);
    cyc();
    bus.start = 1'b0;
    bus.posedge_big_clk = 1'b0;
    check("busy_after_start", 32'(bus.busy), 1);
    if (tick_start) repeat (2) cyc();
    big_tick(11'd777, hold, 1'b0, 0);
    for (int i = 0; i < n; i++) begin
      big_tick(drv[i], hold, 1'b1, i);
      if (poke && i == 0) begin
        bus.start     = 1'b1;
        bus.seq_len   = 7'd2;
        bus.load_en   = 1'b1;
        bus.load_addr = 6'd1;
        bus.load_data = 12'd7;
        cyc();
        bus.start   = 1'b0;
        bus.load_en = 1'b0;
        check("busy_after_poke", 32'(bus.busy), 1);
      end
      if (i + 1 == rst_after) begin
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        check("sb_empty_at_rst", 32'(sb.size()), 0);
        repeat (2) cyc();
        rst_n = 1'b1;
        return;
      end
    end
    cyc();
    @(negedge clk);
    check("run_done", 32'(bus.done), 1);
    check("run_busy", 32'(bus.busy), 0);
    check("run_pass", 32'(bus.pass), 32'(m_cnt == 0));
    check("run_mcount", 32'(bus.mismatch_count), 32'(m_cnt));
    check("run_ffi", 32'(bus.first_fail_idx), 32'(m_ffi));
    check("run_sb_empty", 32'(sb.size()), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.posedge_big_clk = 1'b0;
    bus.output_signal   = '0;
    bus.start           = 1'b0;
    bus.seq_len         = '0;
    bus.load_en         = 1'b0;
    bus.load_addr       = '0;
    bus.load_data       = '0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    cyc();

    // Matching sequence
    load_table();
    drv = '{11'd5, 11'd100, 11'd0, 11'd2047};
    run(4, 1, -1, 1'b0, 1'b0);
    check("t1_pass", 32'(bus.pass), 1);

    // Two mismatches, first at index 1
    drv = '{11'd5, 11'd99, 11'd1, 11'd2047};
    run(4, 1, -1, 1'b0, 1'b0);
    check("t2_mcount", 32'(bus.mismatch_count), 2);
    check("t2_ffi", 32'(bus.first_fail_idx), 1);
    check("t2_pass", 32'(bus.pass), 0);

    // Don't-care on index 2
    load(2, 12'(1 << DC_BIT));
    drv = '{11'd5, 11'd100, 11'd1234, 11'd2047};
    run(4, 1, -1, 1'b0, 1'b0);
    check("t3_mcount", 32'(bus.mismatch_count), 0);

    // Strobe held three cycles per time unit
    load(2, 12'd0);
    drv = '{11'd5, 11'd100, 11'd0, 11'd2047};
    run(4, 3, -1, 1'b0, 1'b0);
    check("t4_pass", 32'(bus.pass), 1);

    // Empty sequence finishes one cycle after start
    bus.start   = 1'b1;
    bus.seq_len = 7'd0;
    cyc();
    bus.start = 1'b0;
    check("len0_done", 32'(bus.done), 1);
    check("len0_pass", 32'(bus.pass), 1);
    check("len0_busy", 32'(bus.busy), 0);

    // start and load_en while busy are ignored
    run(4, 1, -1, 1'b0, 1'b1);
    check("poke_pass", 32'(bus.pass), 1);
    check("poke_mem1", 32'(dut.expected_memory[1]), 100);

    // Asynchronous reset after two samples, then a clean run
    run(4, 1, 2, 1'b0, 1'b0);
    run(4, 1, -1, 1'b0, 1'b0);
    check("post_rst_pass", 32'(bus.pass), 1);

    // start coincides with a tick: that tick is discarded
    run(4, 1, -1, 1'b1, 1'b0);
    check("tick_start_pass", 32'(bus.pass), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
